matvec_out_requant: RTL and testbench
=====================================

Name: matvec_out_requant

Overview:
- Downstream stage of matvec3_part1. Consumes its 28-bit signed y outputs over a valid/ready handshake.
- Rounds, shifts and saturates each value to 14-bit signed, then buffers it in a small FIFO.
- Emits the results with a per-vector last tag, so the outputs can feed a further matvec stage with the same 14-bit input format (chained layers).

Parameters:
- IN_W, 28, input sample width (signed).
- OUT_W, 14, output sample width (signed).
- SHIFT, 7, right-shift amount applied after rounding; must be ≥1.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- VEC_LEN, 3, outputs per vector; used for the out_last tag.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  upstream data valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  IN_W  signed y value from matvec3_part1.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  OUT_W  requantized signed value.
- out_last  out  1  head entry is element VEC_LEN-1 of its vector.
- sat_count  out  16  number of accepted samples that were clamped.

Behaviour:
- Handshakes:
  - Input transfer happens when in_valid && in_ready at a rising edge.
  - Output transfer happens when out_valid && out_ready at a rising edge.
  - in_data is ignored (may be X) when in_valid=0.
- Requantization (combinational on in_data, result written to FIFO):
  - t = in_data + 2^(SHIFT-1), computed in IN_W+1 bits, so there is no wrap.
  - q = t >>> SHIFT (arithmetic shift; round-half-up).
  - Saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-8192, 8191] at defaults.
  - sat flag = 1 if clamping occurred.
- FIFO:
  - Storage is DEPTH entries of {last_tag, OUT_W data}, with a circular write pointer, read pointer and occupancy count.
  - in_ready = (count < DEPTH), combinational from registered count only. There is no same-cycle bypass: when full, in_ready=0 even if out_ready=1.
  - out_valid = (count != 0). out_data and out_last are driven from the head entry, are registered storage, and stay stable while out_valid && !out_ready.
  - Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
  - Pointer wrap-around: DEPTH-1 → 0.
- Latency: a sample accepted at edge N is visible on out_valid/out_data after edge N (usable at edge N+1) when the FIFO was empty. Otherwise it appears after all earlier entries are popped. Ordering is strict FIFO.
- Last tag:
  - An element counter 0..VEC_LEN-1 increments on each input transfer and wraps to 0 after VEC_LEN-1.
  - last_tag = (counter == VEC_LEN-1) at accept time.
- sat_count: increments on each input transfer whose sat flag = 1; it holds at 0xFFFF instead of wrapping.
- Reset (reset=0, asynchronous, any time including mid-transfer):
  - Clears pointers, count, element counter and sat_count to 0.
  - Forces out_valid=0 and in_ready=0 while reset=0.
  - FIFO data contents are don't-care.
  - out_data and out_last read as 0 after reset.
  - Any in-flight vector is discarded. The first input after reset is element 0.
- out_data, out_last and out_valid never change while out_valid && !out_ready, except through reset.

Optional Feature:
- Macro: MATVEC_OUT_REQUANT_RELU_EN.
- Defined: a ReLU is applied before rounding. Negative in_data yields q=0 and sat flag=0. Positive values behave as above, including saturation at 8191.
- Undefined: the signed path is used unchanged. Negative outputs are preserved and saturate at -8192.

Test Plan:
- Basic stream:
  - Stimulus: in -800, -1200, 8400 with out_ready=1.
  - Expected: out -6, -9, 66; out_last = 0, 0, 1; sat_count=0.
- Rounding boundaries:
  - Stimulus: in 64, -64, 63, -65.
  - Expected: out 1, 0, 0, -1.
- Saturation:
  - Stimulus: in 2000000, -2000000.
  - Expected: out 8191, -8192; sat_count=2.
  - With MATVEC_OUT_REQUANT_RELU_EN: out 8191, 0; sat_count=1.
- Backpressure and full:
  - Stimulus: out_ready=0, push 5 valid samples.
  - Expected: in_ready drops after 4 accepts. The head value is held stable. Raising out_ready drains all 4 in order, in_ready returns to 1, and the 5th sample is accepted and emitted last.
- Random throttling:
  - Stimulus: 12 samples with random in_valid and out_ready (≈50%), simultaneous push/pop occurring.
  - Expected: all 12 outputs in order, exact values, out_last every 3rd, no X on out_data while out_valid=1.
- Reset mid-operation:
  - Stimulus: 2 samples accepted and unread, then reset=0 asynchronously between edges.
  - Expected: out_valid=0 immediately. After release, the next 3 inputs produce out_last = 0, 0, 1, and sat_count=0.

Source files
------------

// File: rtl/matvec_out_requant.sv
// Requantizes 28-bit signed matvec results to 14-bit signed and buffers them in a small FIFO,
// tagging the last element of each vector. Define MATVEC_OUT_REQUANT_RELU_EN to clamp negative inputs to zero.
module matvec_out_requant #(
  parameter int IN_W    = 28,
  parameter int OUT_W   = 14,
  parameter int SHIFT   = 7,
  parameter int DEPTH   = 4,
  parameter int VEC_LEN = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last,
  output logic [15:0]             sat_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int EC_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);
  localparam logic [EC_W-1:0]       LAST_C  = EC_W'(VEC_LEN - 1);
  localparam logic signed [IN_W:0]  HALF    = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0]  Q_MAX   = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0]  Q_MIN   = ~Q_MAX;

  logic [OUT_W:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [EC_W-1:0]    elem_q, elem_d;
  logic [15:0]        sat_cnt_q, sat_cnt_d;

  logic signed [IN_W:0]    t_w;
  logic signed [IN_W:0]    q_w;
  logic signed [OUT_W-1:0] q_sat;
  logic                    sat;
  logic                    push, pop, last_tag;

  // One extra bit of headroom keeps the rounding offset from wrapping at the top of the range.
  always_comb begin
    t_w   = {in_data[IN_W-1], in_data} + HALF;
    q_w   = t_w >>> SHIFT;
    q_sat = q_w[OUT_W-1:0];
    sat   = 1'b0;
    if (q_w > Q_MAX) begin
      q_sat = Q_MAX[OUT_W-1:0];
      sat   = 1'b1;
    end else if (q_w < Q_MIN) begin
      q_sat = Q_MIN[OUT_W-1:0];
      sat   = 1'b1;
    end
`ifdef MATVEC_OUT_REQUANT_RELU_EN
    if (in_data[IN_W-1]) begin
      q_sat = '0;
      sat   = 1'b0;
    end
`endif
  end

  assign in_ready  = reset && (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rptr_q][OUT_W-1:0];
  assign out_last  = mem_q[rptr_q][OUT_W];
  assign sat_count = sat_cnt_q;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign last_tag = (elem_q == LAST_C);

  always_comb begin
    wptr_d    = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d    = pop ? rptr_q + PTR_W'(1) : rptr_q;
    count_d   = count_q;
    elem_d    = elem_q;
    sat_cnt_d = sat_cnt_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push) begin
      elem_d = last_tag ? '0 : elem_q + EC_W'(1);
      if (sat && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      elem_q    <= '0;
      sat_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      elem_q    <= elem_d;
      sat_cnt_q <= sat_cnt_d;
      if (push) mem_q[wptr_q] <= {last_tag, q_sat};
    end
  end

endmodule

// File: tb/tb_matvec_out_requant.sv
// Self-checking bench for matvec_out_requant: vector table, backpressure, random throttling and mid-run reset,
// with a queue-based reference model observing every transfer.
module tb_matvec_out_requant;
  localparam int SHIFT = 7;
  localparam int QMAX  = 8191;
  localparam int QMIN  = -8192;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_data;
  logic        out_last;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  matvec_out_requant dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sat_count (sat_count)
  );

  typedef struct {int d; bit l;} ent_t;
  typedef struct {int din; int exp_d; bit exp_l; bit exp_s;} vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t m_q[$];
  int   m_elem  = 0;
  int   m_sat   = 0;
  int   m_pops  = 0;
  bit   done    = 1'b0;
  bit   hold_v  = 1'b0;
  int   hold_d  = 0;
  bit   hold_l  = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: round half up by floor division, then clamp (or ReLU when enabled).
  function automatic void model(input int x, output int q, output bit s);
    longint t, f, dv;
    dv = longint'(1) << SHIFT;
    t  = longint'(x) + (dv / 2);
    f  = (t >= 0) ? t / dv : -((-t + dv - 1) / dv);
    s  = 1'b0;
    if (f > QMAX) begin f = QMAX; s = 1'b1; end
    else if (f < QMIN) begin f = QMIN; s = 1'b1; end
`ifdef MATVEC_OUT_REQUANT_RELU_EN
    if (x < 0) begin f = 0; s = 1'b0; end
`endif
    q = int'(f);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!out_valid && m_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(nm, ok, 1);
  endtask

  vec_t tv[13];
  int   sent, cyc, p0, v, exp_sat, ed;
  bit   acc, es;
  ent_t e;
  int   mq;
  bit   ms;

  initial begin
    tv[0]  = '{-800,     -6,    1'b0, 1'b0};
    tv[1]  = '{-1200,    -9,    1'b0, 1'b0};
    tv[2]  = '{8400,     66,    1'b1, 1'b0};
    tv[3]  = '{64,       1,     1'b0, 1'b0};
    tv[4]  = '{-64,      0,     1'b0, 1'b0};
    tv[5]  = '{63,       0,     1'b1, 1'b0};
    tv[6]  = '{-65,      -1,    1'b0, 1'b0};
    tv[7]  = '{2000000,  8191,  1'b0, 1'b1};
    tv[8]  = '{-2000000, -8192, 1'b1, 1'b1};
    tv[9]  = '{1048448,  8191,  1'b0, 1'b0};
    tv[10] = '{1048512,  8191,  1'b0, 1'b1};
    tv[11] = '{-1048640, -8192, 1'b1, 1'b0};
    tv[12] = '{-1048641, -8192, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    fork
      begin
        #1 reset = 1'b0;
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        @(posedge clk); #3 reset = 1'b1;
        step();
        chk("rel_in_ready", in_ready, 1);

        exp_sat = 0;
        for (int i = 0; i < 13; i++) begin
          ed = tv[i].exp_d;
          es = tv[i].exp_s;
`ifdef MATVEC_OUT_REQUANT_RELU_EN
          if (tv[i].din < 0) begin ed = 0; es = 1'b0; end
`endif
          exp_sat += int'(es);
          v = tv[i].din;
          in_valid = 1'b1; in_data = v[27:0]; out_ready = 1'b1;
          chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
          step();
          in_valid = 1'b0;
          chk($sformatf("vec%0d_valid", i), out_valid, 1);
          chk($sformatf("vec%0d_data", i), $signed(out_data), ed);
          chk($sformatf("vec%0d_last", i), out_last, tv[i].exp_l);
          chk($sformatf("vec%0d_sat_count", i), sat_count, exp_sat);
          step();
          chk($sformatf("vec%0d_drained", i), out_valid, 0);
        end

        // Backpressure: four fill the FIFO, the fifth must wait.
        out_ready = 1'b0;
        p0 = m_pops;
        for (int k = 0; k < 4; k++) begin
          v = (k + 1) * 1280;
          in_valid = 1'b1; in_data = v[27:0];
          chk($sformatf("bp_ready%0d", k), in_ready, 1);
          step();
        end
        v = 5 * 1280;
        in_data = v[27:0];
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("bp_full%0d", k), in_ready, 0);
          chk($sformatf("bp_head%0d", k), $signed(out_data), 10);
          step();
        end
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
          acc = in_ready;
          step();
          if (acc) break;
        end
        chk("bp_5th_accepted", acc, 1);
        in_valid = 1'b0;
        drain("bp_drain");
        chk("bp_pops", m_pops - p0, 5);
        chk("bp_in_ready_back", in_ready, 1);

        // Random throttling on both sides.
        p0 = m_pops; sent = 0; cyc = 0;
        while (sent < 12 && cyc < 2000) begin
          out_ready = 1'($urandom % 2);
          in_valid  = 1'($urandom % 2);
          case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(0, 40000)) - 20000;
            1:       v = int'($urandom_range(0, 4000000)) - 2000000;
            2:       v = int'($urandom_range(0, 255)) - 128;
            default: v = int'($urandom) >>> 4;
          endcase
          in_data = v[27:0];
          if (in_valid && in_ready) sent++;
          step();
          cyc++;
        end
        chk("rnd_sent", sent, 12);
        in_valid = 1'b0; out_ready = 1'b1;
        drain("rnd_drain");
        chk("rnd_pops", m_pops - p0, 12);
        chk("rnd_sat_count", sat_count, m_sat);

        // Asynchronous reset with two entries pending.
        out_ready = 1'b0;
        v = 3000; in_valid = 1'b1; in_data = v[27:0]; step();
        v = 4000; in_data = v[27:0]; step();
        in_valid = 1'b0;
        chk("mid_pending_valid", out_valid, 1);
        @(posedge clk); #3 reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_sat_count", sat_count, 0);
        #2 reset = 1'b1;
        step();
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
          v = (j == 1) ? -6400 : 6400 + j;
          in_valid = 1'b1; in_data = v[27:0];
          step();
          chk($sformatf("post_rst_last%0d", j), out_last, (j == 2) ? 1 : 0);
        end
        in_valid = 1'b0;
        drain("post_rst_drain");
        chk("post_rst_sat_count", sat_count, 0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk or negedge reset);
          if (!reset) begin
            m_q.delete();
            m_elem = 0;
            m_sat  = 0;
            hold_v = 1'b0;
          end else begin
            if (hold_v) begin
              chk("hold_valid", out_valid, 1);
              chk("hold_data", $signed(out_data), hold_d);
              chk("hold_last", out_last, hold_l);
            end
            if (out_valid) chk("out_data_known", $isunknown(out_data), 0);
            if (out_valid && out_ready) begin
              if (m_q.size() == 0) chk("pop_unexpected", 1, 0);
              else begin
                e = m_q.pop_front();
                chk("pop_data", $signed(out_data), e.d);
                chk("pop_last", out_last, e.l);
              end
              m_pops++;
            end
            if (in_valid && in_ready) begin
              model(int'($signed(in_data)), mq, ms);
              e.d = mq;
              e.l = (m_elem == 2);
              m_q.push_back(e);
              m_elem = (m_elem == 2) ? 0 : m_elem + 1;
              if (ms && m_sat < 65535) m_sat++;
            end
            hold_v = out_valid && !out_ready;
            hold_d = int'($signed(out_data));
            hold_l = out_last;
          end
        end
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
